// File: rtl/des_decrypt_core_if.sv
// Block-in / block-out handshake bundle for des_decrypt_core.
// The decrypt mode pin exists only when DES_DIR_SEL_EN is defined.
interface des_decrypt_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ct_in;
  logic [63:0] key_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pt_out;
`ifdef DES_DIR_SEL_EN
  logic        decrypt;
  modport slave  (input  in_valid, ct_in, key_in, out_ready, decrypt,
                  output in_ready, out_valid, pt_out);
  modport master (output in_valid, ct_in, key_in, out_ready, decrypt,
                  input  in_ready, out_valid, pt_out);
`else
  modport slave  (input  in_valid, ct_in, key_in, out_ready,
                  output in_ready, out_valid, pt_out);
  modport master (output in_valid, ct_in, key_in, out_ready,
                  input  in_ready, out_valid, pt_out);
`endif
endinterface

// File: rtl/des_decrypt_core.sv
// Iterative single-DES core, one Feistel round per clock, reverse key schedule on the fly.
// Optional macro DES_DIR_SEL_EN adds a decrypt pin and an encrypt mode (left-rotate schedule).
//
// state | meaning
// IDLE  | in_ready high, waiting for a block
// ROUND | one Feistel round per cycle, rnd 0..15
// DONE  | out_valid high, pt_out held until out_ready

module s_box1 (input logic [5:0] b, output logic [3:0] s);
  localparam logic [255:0] T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  logic [7:0] pos;
  assign pos = {~b[5], ~b[0], ~b[4:1], 2'b00};
  assign s   = T[pos +: 4];
endmodule

module s_box2 (input logic [5:0] b, output logic [3:0] s);
  localparam logic [255:0] T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  logic [7:0] pos;
  assign pos = {~b[5], ~b[0], ~b[4:1], 2'b00};
  assign s   = T[pos +: 4];
endmodule

module s_box3 (input logic [5:0] b, output logic [3:0] s);
  localparam logic [255:0] T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  logic [7:0] pos;
  assign pos = {~b[5], ~b[0], ~b[4:1], 2'b00};
  assign s   = T[pos +: 4];
endmodule

module s_box4 (input logic [5:0] b, output logic [3:0] s);
  localparam logic [255:0] T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  logic [7:0] pos;
  assign pos = {~b[5], ~b[0], ~b[4:1], 2'b00};
  assign s   = T[pos +: 4];
endmodule

module s_box5 (input logic [5:0] b, output logic [3:0] s);
  localparam logic [255:0] T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  logic [7:0] pos;
  assign pos = {~b[5], ~b[0], ~b[4:1], 2'b00};
  assign s   = T[pos +: 4];
endmodule

module s_box6 (input logic [5:0] b, output logic [3:0] s);
  localparam logic [255:0] T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  logic [7:0] pos;
  assign pos = {~b[5], ~b[0], ~b[4:1], 2'b00};
  assign s   = T[pos +: 4];
endmodule

module s_box7 (input logic [5:0] b, output logic [3:0] s);
  localparam logic [255:0] T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  logic [7:0] pos;
  assign pos = {~b[5], ~b[0], ~b[4:1], 2'b00};
  assign s   = T[pos +: 4];
endmodule

module s_box8 (input logic [5:0] b, output logic [3:0] s);
  localparam logic [255:0] T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
  logic [7:0] pos;
  assign pos = {~b[5], ~b[0], ~b[4:1], 2'b00};
  assign s   = T[pos +: 4];
endmodule

module des_decrypt_core (
  input  logic               clk,
  input  logic               rst,
  des_decrypt_core_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                               64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                               37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // bit n set = shift by two in round n, otherwise by one
  localparam logic [15:0] RS_TWO = 16'h3F7E;

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction
  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction
  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction
  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_q, state_nxt;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [3:0]  rnd_q;
  logic [63:0] pt_q;
  logic [27:0] c_key, d_key, c_nxt, d_nxt;
  logic [47:0] k, e_x;
  logic [31:0] s_out, f;

`ifdef DES_DIR_SEL_EN
  localparam logic [15:0] LS_TWO = 16'h7EFC;
  logic mode_q;

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) mode_q <= 1'b1;
    else if (state_q == IDLE && bus.in_valid) mode_q <= bus.decrypt;
  end

  // encrypt rotates before the subkey is taken; decrypt uses the current C/D then rotates
  always_comb begin
    c_key = c_q;
    d_key = d_q;
    c_nxt = rotr(c_q, RS_TWO[rnd_q]);
    d_nxt = rotr(d_q, RS_TWO[rnd_q]);
    if (!mode_q) begin
      c_key = rotl(c_q, LS_TWO[rnd_q]);
      d_key = rotl(d_q, LS_TWO[rnd_q]);
      c_nxt = c_key;
      d_nxt = d_key;
    end
  end
`else
  assign c_key = c_q;
  assign d_key = d_q;
  assign c_nxt = rotr(c_q, RS_TWO[rnd_q]);
  assign d_nxt = rotr(d_q, RS_TWO[rnd_q]);
`endif

  assign k   = pc2({c_key, d_key});
  assign e_x = e_exp(r_q) ^ k;

  s_box1 u_s1 (.b(e_x[47:42]), .s(s_out[31:28]));
  s_box2 u_s2 (.b(e_x[41:36]), .s(s_out[27:24]));
  s_box3 u_s3 (.b(e_x[35:30]), .s(s_out[23:20]));
  s_box4 u_s4 (.b(e_x[29:24]), .s(s_out[19:16]));
  s_box5 u_s5 (.b(e_x[23:18]), .s(s_out[15:12]));
  s_box6 u_s6 (.b(e_x[17:12]), .s(s_out[11:8]));
  s_box7 u_s7 (.b(e_x[11:6]),  .s(s_out[7:4]));
  s_box8 u_s8 (.b(e_x[5:0]),   .s(s_out[3:0]));

  assign f = p_perm(s_out);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)      state_nxt = ROUND;
      ROUND:   if (rnd_q == 4'd15)    state_nxt = DONE;
      DONE:    if (bus.out_ready)     state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.pt_out    = pt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      rnd_q <= '0;
      pt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          {l_q, r_q} <= ip(bus.ct_in);
          {c_q, d_q} <= pc1(bus.key_in);
          rnd_q      <= '0;
        end
        ROUND: begin
          l_q   <= r_q;
          r_q   <= l_q ^ f;
          c_q   <= c_nxt;
          d_q   <= d_nxt;
          rnd_q <= rnd_q + 4'd1;
          // final swap: output is R16 on the left
          if (rnd_q == 4'd15) pt_q <= fp({l_q ^ f, r_q});
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: driver pushes expected plaintext and accept cycle,
// a negedge monitor pops and compares on each output handshake and on each out_valid rise.
module tb_des_decrypt_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_decrypt_core_if bus ();
  des_decrypt_core dut (.clk(clk), .rst(rst), .bus(bus));

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                               64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                              19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                              14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                              41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Textbook DES: full left-shift schedule first, subkeys applied in reverse to decrypt.
  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [63:0] key, input bit enc);
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [63:0] x, y;
    logic [31:0] l, r, t, f, sb;
    logic [47:0] ex;
    logic [5:0]  b;
    int row, col;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SHIFT[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-PC2[i]];
    end
    for (int i = 0; i < 64; i++) x[63-i] = blk[64-IP_T[i]];
    l = x[63:32];
    r = x[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int i = 0; i < 48; i++) ex[47-i] = r[32-E_T[i]];
      ex = ex ^ (enc ? ks[rd] : ks[15-rd]);
      for (int j = 0; j < 8; j++) begin
        b   = ex[47-6*j -: 6];
        row = int'(b[5]) * 2 + int'(b[0]);
        col = int'(b[4:1]);
        sb[31-4*j -: 4] = 4'(SB[j][row*16+col]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = sb[32-P_T[i]];
      t = r;
      r = l ^ f;
      l = t;
    end
    x = {r, l};
    for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
    return y;
  endfunction

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;
  bit rand_rdy = 1'b0;
  bit ov_prev = 1'b0;
  logic [63:0] exp_q [$];
  int acc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  always @(negedge clk) begin
    if (rst) ov_prev = 1'b0;
    else begin
      if (bus.out_valid && !ov_prev) begin
        if (acc_q.size() == 0) fail("spurious out_valid");
        else check("latency", 64'(cyc - acc_q.pop_front()), 64'd16);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail("unexpected output handshake");
        else check("pt_out", bus.pt_out, exp_q.pop_front());
      end
      ov_prev = bus.out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Leaves in_valid high after the accept edge; the caller decides when to drop it.
  task automatic send(input logic [63:0] ct, input logic [63:0] key, input logic [63:0] exp, input bit dec);
    bus.in_valid = 1'b1;
    bus.ct_in    = ct;
    bus.key_in   = key;
`ifdef DES_DIR_SEL_EN
    bus.decrypt  = dec;
`endif
    for (int w = 0; w < 100; w++) begin
      if (bus.in_ready) begin
        exp_q.push_back(exp);
        acc_q.push_back(cyc + 1);
        last_acc = cyc + 1;
        tick();
        return;
      end
      tick();
    end
    fail("accept timeout");
  endtask

  task automatic send_rand(input bit dec);
    logic [63:0] ct, key;
    ct  = {$urandom, $urandom};
    key = {$urandom, $urandom};
    send(ct, key, des_model(ct, key, !dec), dec);
  endtask

  task automatic drain();
    for (int w = 0; w < 400; w++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    fail("drain timeout");
    exp_q.delete();
    acc_q.delete();
  endtask

  initial begin
    int a_acc;
    logic [63:0] hold, ct, key;
    bit seen;
    bus.in_valid  = 1'b0;
    bus.ct_in     = '0;
    bus.key_in    = '0;
    bus.out_ready = 1'b1;
`ifdef DES_DIR_SEL_EN
    bus.decrypt   = 1'b1;
`endif
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset pt_out", bus.pt_out, 64'h0);

    send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    send(64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    send(64'h85E813540F0AB405, 64'h123556789ABDDEF0, 64'h0123456789ABCDEF, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    // backpressure: result held, in_valid pulses ignored while DONE
    bus.out_ready = 1'b0;
    ct   = {$urandom, $urandom};
    key  = {$urandom, $urandom};
    hold = des_model(ct, key, 1'b0);
    send(ct, key, hold, 1'b1);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      if (bus.out_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) fail("out_valid timeout");
    for (int w = 0; w < 10; w++) begin
      check("bp pt_out stable", bus.pt_out, hold);
      check("bp in_ready", 64'(bus.in_ready), 64'd0);
      check("bp out_valid", 64'(bus.out_valid), 64'd1);
      bus.in_valid = 1'(w & 1);
      bus.ct_in    = {$urandom, $urandom};
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp release out_valid", 64'(bus.out_valid), 64'd0);
    check("bp release in_ready", 64'(bus.in_ready), 64'd1);

    // reset at round 7 aborts the block
    send_rand(1'b1);
    bus.in_valid = 1'b0;
    for (int w = 0; w < 7; w++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort pt_out", bus.pt_out, 64'h0);
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    send_rand(1'b1);
    bus.in_valid = 1'b0;
    drain();

    // busy input: second block held on the bus is taken only after the handshake
    send_rand(1'b1);
    a_acc = last_acc;
    send_rand(1'b1);
    bus.in_valid = 1'b0;
    check("busy accept gap", 64'(last_acc - a_acc), 64'd18);
    drain();

    rand_rdy = 1'b1;
    for (int n = 0; n < 25; n++) begin
      send_rand(1'b1);
      bus.in_valid = 1'b0;
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    drain();
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;

`ifdef DES_DIR_SEL_EN
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0);
    bus.in_valid = 1'b0;
    drain();
    for (int n = 0; n < 10; n++) begin
      send_rand(1'($urandom_range(0, 1)));
      bus.in_valid = 1'b0;
    end
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/des_decrypt_core.md
# des_decrypt_core

Iterative single-DES decryption engine: accepts a 64-bit ciphertext block and 64-bit key over a valid/ready handshake, runs 16 Feistel rounds at one round per clock with an on-the-fly reverse key schedule, and returns the 64-bit plaintext over a second valid/ready handshake. It sits downstream of the block-input logic as the decrypt-direction counterpart of the encryption datapath. It instantiates the existing s_box1..s_box8 substitution modules for the round function, one instance each.

## Interface
- No parameters; DES widths are fixed.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  ct_in/key_in valid.
- in_ready  output  1  core can accept a block; high only in IDLE.
- ct_in  input  64  ciphertext block, bit 63 = DES bit 1.
- key_in  input  64  DES key including parity bits; bits 56,48,…,0 (DES bits 8,16,…,64) ignored.
- out_valid  output  1  pt_out valid.
- out_ready  input  1  downstream accepts pt_out.
- pt_out  output  64  plaintext block, registered.
- decrypt  input  1  present only with DES_DIR_SEL_EN; see Configuration.

## Operation
- States: IDLE, ROUND, DONE. Round counter rnd[3:0].
- IDLE: in_ready=1. On in_valid: L/R ← IP(ct_in); C/D ← PC-1(key_in); rnd ← 0; go to ROUND.
- ROUND, each cycle: K = PC-2(C,D); f = P(S1..S8(E(R) ^ K)); L ← R; R ← L ^ f; C/D each rotate right by RS[rnd]; rnd ← rnd+1.
- RS[0..15] = 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1,1. Round 0 uses C0D0 unrotated (= K16); total rotation after 16 rounds is 28, restoring C0D0.
- At rnd=15: pt_out ← FP({R_new, L_new}) (final swap included); go to DONE.
- DONE: out_valid=1, pt_out held stable. On out_ready: out_valid ← 0; go to IDLE.
- S-box indexing: each 6-bit group b5..b0 addresses row {b5,b0}, column b4..b1. S1 takes the most-significant group.
- in_valid outside IDLE is ignored; no queueing.
- No back-to-back overlap: a new block is not accepted in the DONE→IDLE transition cycle.

## Timing
- Reset (rst high at a clock edge): state IDLE, rnd=0, out_valid=0, pt_out=64'h0, L/R/C/D=0; in_ready=1 from the first cycle after reset.
- rst during ROUND or DONE aborts the block. No output is produced for it, and pt_out clears to 0.
- Accept edge = edge with in_valid & in_ready; that is cycle 0.
- Rounds occur on edges 1..16. out_valid rises after edge 16, so latency is 16 cycles from accept.
- Throughput: one block per 18 cycles minimum (accept, 16 rounds, output handshake, 1 IDLE cycle).
- out_valid and pt_out are registered; in_ready is decoded from the state register.
- No combinational path from any input to any output.

## Configuration
- Macro: DES_DIR_SEL_EN.
- Defined:
  - decrypt port exists and is sampled at the accept edge into a mode register.
  - Mode 1 behaves as described above.
  - Mode 0 encrypts: C/D rotate left by LS[rnd] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before subkey use. The rotated value is both registered and fed to PC-2.
  - Latency and handshake are identical in both modes.
- Undefined: no decrypt port; the core is decrypt-only, with no mode register or left-rotate logic.

## Test plan
- Known vector: key 133457799BBCDFF1, ct 85E813540F0AB405 → pt_out 0123456789ABCDEF, out_valid exactly 16 cycles after the accept edge. During round 0 the internal subkey is CB3D8B0E17F5; during round 15 it is 1B02EFFC7072.
- Second vector plus parity: key 0E329232EA6D0D73, ct 0000000000000000 → 8787878787878787. Key 123556789ABDDEF0 (parity bits flipped) with ct 85E813540F0AB405 → 0123456789ABCDEF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. pt_out is stable, in_ready=0, and in_valid pulses are ignored. Raising out_ready → out_valid falls next edge, in_ready=1.
- Reset mid-operation: assert rst at round 7 for one cycle → next cycle out_valid=0, pt_out=0, in_ready=1. A fresh block then decrypts correctly.
- Busy input: change ct_in/key_in and hold in_valid=1 during ROUND → the result matches the originally accepted block. The second block is accepted only after the output handshake.
- With DES_DIR_SEL_EN, decrypt=0: key 133457799BBCDFF1, input 0123456789ABCDEF → 85E813540F0AB405, same 16-cycle latency.
